// File: rtl/seq_shifter.sv
// Multi-cycle shift unit (SLL/SRL/SRA, optional ROTR) moving up to STEP bits per clock.
// Define SEQ_SHIFTER_ROTATE_EN to enable op 11 as rotate-right; otherwise op 11 acts as SLL.
module seq_shifter #(
    parameter int WIDTH   = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // STEP can equal WIDTH, so it needs one bit more than a shift amount
    localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W + 1)'(STEP);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               accept_s;
    logic [SHAMT_W-1:0] step_amt_s;
    logic [SHAMT_W-1:0] cnt_next_s;
    logic [WIDTH-1:0]   acc_shift_s;

    function automatic logic [WIDTH-1:0] shift_once(
        input logic [1:0]         mode,
        input logic [WIDTH-1:0]   val,
        input logic [SHAMT_W-1:0] amt
    );
        logic [WIDTH-1:0] res;
        res = val << amt;
        case (mode)
            2'b00:   res = val << amt;
            2'b01:   res = val >> amt;
            // MSB of the accumulator never changes under SRA, so it is the captured sign
            2'b10:   res = $signed(val) >>> amt;
`ifdef SEQ_SHIFTER_ROTATE_EN
            // Left amount is (WIDTH - amt) mod WIDTH; amt == 0 degenerates to val | val
            2'b11:   res = (val >> amt) | (val << (SHAMT_W'(0) - amt));
`else
            2'b11:   res = val << amt;
`endif
            default: res = val << amt;
        endcase
        return res;
    endfunction

    assign accept_s    = start && (state_q != ST_SHIFT);
    assign step_amt_s  = ({1'b0, cnt_q} < STEP_W) ? cnt_q : STEP_W[SHAMT_W-1:0];
    assign cnt_next_s  = cnt_q - step_amt_s;
    assign acc_shift_s = shift_once(op_q, acc_q, step_amt_s);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_d = (shamt == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_next_s == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy   = (state_q == ST_SHIFT);
        done   = (state_q == ST_DONE);
        result = result_q;
    end

    // Datapath next values: operand capture, per-cycle step, result load
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    acc_d = data_in;
                    cnt_d = shamt;
                    op_d  = op;
                    if (shamt == '0) begin
                        result_d = data_in;
                    end else begin
                        result_d = result_q;
                    end
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_SHIFT: begin
                acc_d = acc_shift_s;
                cnt_d = cnt_next_s;
                if (cnt_next_s == '0) begin
                    result_d = acc_shift_s;
                end else begin
                    result_d = result_q;
                end
            end
            default: begin
                acc_d = '0;
                cnt_d = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= 2'b00;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Multi-cycle, parametrised shift unit that generalises the fixed `<<2` branch-offset shifter into a variable-amount, multi-mode shifter. Supports logical left, logical right and arithmetic right shifts, plus an optional rotate. It moves STEP bit positions per clock under a start/done handshake. It serves the datapath's shift instructions (SLL/SRL/SRA and the variable forms) and any future multi-cycle execute stage.

## Interface
Parameters:
- WIDTH, 32: data width in bits; power of two, at least 4.
- STEP, 1: bit positions shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH.
- SHAMT_W, $clog2(WIDTH): shift-amount width. Derived; never overridden.

Ports:
- clk: input, 1 bit. Single clock, rising edge.
- rst_n: input, 1 bit. Reset, asynchronous, active-low.
- start: input, 1 bit. Request; sampled on the rising edge.
- op: input, 2 bits. 00 SLL, 01 SRL, 10 SRA, 11 ROTR (see Configuration).
- data_in: input, WIDTH bits. Operand; captured when start is accepted.
- shamt: input, SHAMT_W bits. Shift amount, 0..WIDTH-1; captured when start is accepted.
- busy: output, 1 bit. High while shifting (SHIFT state).
- done: output, 1 bit. One-cycle pulse; result is valid from this cycle onward.
- result: output, WIDTH bits. Shifted value; held until the next completion.

## Operation
- States: IDLE, SHIFT, DONE.
- start is accepted in IDLE or DONE.
  - On acceptance, op is latched, the accumulator is loaded with data_in, and the counter is loaded with shamt.
  - start in SHIFT is ignored. Latched operands are unaffected.
- Transition from IDLE or DONE on acceptance:
  - shamt == 0: go to DONE; result <= data_in.
  - Otherwise: go to SHIFT.
- In SHIFT, each edge shifts the accumulator by s = min(STEP, cnt) and sets cnt <= cnt - s.
  - When the new cnt is 0, go to DONE and load result with the final accumulator value in the same edge.
- DONE lasts exactly one cycle. It returns to IDLE, or re-enters SHIFT/DONE if a new start is accepted (back-to-back).
- Fill rules:
  - SLL: zero-fill LSBs.
  - SRL: zero-fill MSBs.
  - SRA: fill MSBs with bit WIDTH-1 of the captured data_in.
  - ROTR: bits leaving the LSB re-enter at the MSB.
- Changes on data_in, shamt or op after acceptance have no effect.
- Outputs:
  - busy = (state == SHIFT).
  - done = (state == DONE).
  - result is registered and changes only on the edge that enters DONE.

## Timing
- Reset (rst_n low, asynchronous, at any time, including mid-SHIFT):
  - state = IDLE, busy = 0, done = 0, result = 0, accumulator and counter = 0.
  - The in-flight operation is discarded.
- Release: the first start is accepted on the first rising edge at which rst_n is high.
- Latency: done is high L cycles after the cycle in which start is accepted, where L = 1 + ceil(shamt/STEP).
  - shamt = 0 gives L = 1.
  - shamt = WIDTH-1 with STEP = 1 gives L = WIDTH.
- Throughput: one result per L cycles. No idle gap is required between operations, since start is accepted during DONE.
- A partial final step (cnt < STEP) shifts exactly cnt positions.

## Configuration
- Macro: SEQ_SHIFTER_ROTATE_EN.
  - Defined: op 11 performs ROTR as specified above.
  - Undefined: rotate logic is compiled out, and op 11 behaves exactly as SLL (00), including latency.

## Test plan
- SLL, WIDTH=32, STEP=1, data_in=0x0000_0001, shamt=4 -> busy high 4 cycles; done at L=5; result=0x0000_0010.
- SRA, STEP=1, data_in=0x8000_0000, shamt=31 -> done at L=32; result=0xFFFF_FFFF. The same operand with SRL gives 0x0000_0001.
- shamt=0, op=SRL, data_in=0xDEAD_BEEF -> done at L=1; result=0xDEAD_BEEF; busy never asserted.
- STEP=4, SRL, data_in=0xF000_0000, shamt=7 -> steps of 4 then 3; done at L=3; result=0x01E0_0000.
- Collision cases:
  - start with data_in=0x1234_5678 pulsed mid-SHIFT -> ignored; the original result is unaffected.
  - rst_n pulled low mid-SHIFT -> busy, done and result immediately 0; no done follows.
  - A new start during DONE -> accepted; the second result is correct.
- op=11, data_in=0x0000_0001, shamt=1:
  - With SEQ_SHIFTER_ROTATE_EN defined -> result=0x8000_0000.
  - Without the macro -> result=0x0000_0002.
